// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: opcode values,
// FSM state encoding, ALU operation codes, datapath mux select codes and the
// packed control word passed from the output decoder to the top level.
package mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        R_EXEC   = 4'd6,
        R_WB     = 4'd7,
        I_EXEC   = 4'd8,
        I_WB     = 4'd9,
        BRANCH   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_FUNCT = 3'b010,
        ALU_AND   = 3'b011,
        ALU_OR    = 3'b100
    } alu_op_t;

    localparam logic [1:0] REG_DST_RT      = 2'b00;
    localparam logic [1:0] REG_DST_RD      = 2'b01;
    localparam logic [1:0] REG_DST_RA      = 2'b10;

    localparam logic [1:0] MEM_TO_REG_ALU  = 2'b00;
    localparam logic [1:0] MEM_TO_REG_MDR  = 2'b01;
    localparam logic [1:0] MEM_TO_REG_PC   = 2'b10;

    localparam logic [1:0] ALU_SRC_B_RT    = 2'b00;
    localparam logic [1:0] ALU_SRC_B_FOUR  = 2'b01;
    localparam logic [1:0] ALU_SRC_B_IMM   = 2'b10;
    localparam logic [1:0] ALU_SRC_B_SH2   = 2'b11;

    localparam logic [1:0] PC_SRC_ALU      = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT   = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP     = 2'b10;

    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic       pcWriteCondNe;
        logic       iord;
        logic       memRead;
        logic       memWrite;
        logic       irWrite;
        logic [1:0] regDst;
        logic [1:0] memToReg;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [2:0] aluOp;
        logic [1:0] pcSource;
        logic       regWrite;
    } ctrl_t;

    // ALU operation for the immediate-arithmetic group, chosen at DECODE.
    function automatic alu_op_t iOpFor(input logic [5:0] opcode);
        case (opcode)
            OP_ANDI: iOpFor = ALU_AND;
            OP_ORI:  iOpFor = ALU_OR;
            default: iOpFor = ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle.
//   instruction, mem_ready : datapath -> controller
//   all remaining signals  : controller -> datapath (control word + debug state)
// master = controller side, slave = datapath side.
interface multicycle_controller_if #(
    parameter int INSTR_WIDTH = 32,
    parameter int ALUOP_WIDTH = 3
);
    logic [INSTR_WIDTH-1:0] instruction;
    logic                   mem_ready;
    logic                   pc_write;
    logic                   pc_write_cond;
    logic                   pc_write_cond_ne;
    logic                   iord;
    logic                   mem_read;
    logic                   mem_write;
    logic                   ir_write;
    logic [1:0]             reg_dst;
    logic [1:0]             mem_to_reg;
    logic                   alu_src_a;
    logic [1:0]             alu_src_b;
    logic [ALUOP_WIDTH-1:0] alu_op;
    logic [1:0]             pc_source;
    logic                   reg_write;
    logic                   illegal_op;
    logic [3:0]             state;

    modport master (
        input  instruction, mem_ready,
        output pc_write, pc_write_cond, pc_write_cond_ne, iord, mem_read,
               mem_write, ir_write, reg_dst, mem_to_reg, alu_src_a,
               alu_src_b, alu_op, pc_source, reg_write, illegal_op, state
    );

    modport slave (
        output instruction, mem_ready,
        input  pc_write, pc_write_cond, pc_write_cond_ne, iord, mem_read,
               mem_write, ir_write, reg_dst, mem_to_reg, alu_src_a,
               alu_src_b, alu_op, pc_source, reg_write, illegal_op, state
    );
endinterface

// File: rtl/multicycle_controller_outputs.sv
// Moore control-word decode: current FSM state plus the instruction class
// latched at DECODE -> datapath control word. Purely combinational.
//   state  : current FSM state
//   iOpSel : ALU op for I_EXEC (add/and/or)
//   isBne  : branch in flight is bne (else beq)
//   isJal  : jump in flight is jal (else j)
//   ctrl   : control word (FETCH write enables are gated by the top level)
module mc_ctrl_outputs
    import mc_ctrl_pkg::*;
(
    input  state_t  state,
    input  alu_op_t iOpSel,
    input  logic    isBne,
    input  logic    isJal,
    output ctrl_t   ctrl
);
    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.memRead = 1'b1;
                ctrl.aluSrcB = ALU_SRC_B_FOUR;
                ctrl.aluOp   = ALU_ADD;
                ctrl.irWrite = 1'b1;
                ctrl.pcWrite = 1'b1;
            end
            DECODE: begin
                ctrl.aluSrcB = ALU_SRC_B_SH2;
                ctrl.aluOp   = ALU_ADD;
            end
            MEM_ADDR: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = ALU_SRC_B_IMM;
                ctrl.aluOp   = ALU_ADD;
            end
            MEM_RD: begin
                ctrl.memRead = 1'b1;
                ctrl.iord    = 1'b1;
            end
            MEM_WB: begin
                ctrl.regWrite = 1'b1;
                ctrl.regDst   = REG_DST_RT;
                ctrl.memToReg = MEM_TO_REG_MDR;
            end
            MEM_WR: begin
                ctrl.memWrite = 1'b1;
                ctrl.iord     = 1'b1;
            end
            R_EXEC: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = ALU_SRC_B_RT;
                ctrl.aluOp   = ALU_FUNCT;
            end
            R_WB: begin
                ctrl.regWrite = 1'b1;
                ctrl.regDst   = REG_DST_RD;
                ctrl.memToReg = MEM_TO_REG_ALU;
            end
            I_EXEC: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = ALU_SRC_B_IMM;
                ctrl.aluOp   = iOpSel;
            end
            I_WB: begin
                ctrl.regWrite = 1'b1;
                ctrl.regDst   = REG_DST_RT;
                ctrl.memToReg = MEM_TO_REG_ALU;
            end
            BRANCH: begin
                ctrl.aluSrcA       = 1'b1;
                ctrl.aluSrcB       = ALU_SRC_B_RT;
                ctrl.aluOp         = ALU_SUB;
                ctrl.pcSource      = PC_SRC_ALUOUT;
                ctrl.pcWriteCond   = ~isBne;
                ctrl.pcWriteCondNe = isBne;
            end
            JUMP: begin
                ctrl.pcWrite  = 1'b1;
                ctrl.pcSource = PC_SRC_JUMP;
                if (isJal) begin
                    ctrl.regWrite = 1'b1;
                    ctrl.regDst   = REG_DST_RA;
                    ctrl.memToReg = MEM_TO_REG_PC;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control unit (Moore FSM).
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; forces FETCH and zeroes all outputs
//   bus   : master side of multicycle_controller_if (instruction/mem_ready in,
//           control word, illegal_op and debug state out)
// Parameters: INSTR_WIDTH (opcode = top 6 bits), ALUOP_WIDTH, HAS_MEM_WAIT
// (0 = mem_ready ignored), ENABLE_JAL (0 = jal is illegal).
module multicycle_controller
    import mc_ctrl_pkg::*;
#(
    parameter int INSTR_WIDTH  = 32,
    parameter int ALUOP_WIDTH  = 3,
    parameter int HAS_MEM_WAIT = 1,
    parameter int ENABLE_JAL   = 1
) (
    input logic clk,
    input logic reset,
    multicycle_controller_if.master bus
);
    state_t     currentState;
    state_t     nextState;
    state_t     dispatchState;
    alu_op_t    iOpSel;
    logic       isBne;
    logic       isJal;
    logic       decodeIllegal;
    logic       memOk;
    logic [5:0] opcode;
    ctrl_t      baseCtrl;
    ctrl_t      ctrlOut;
    logic       illegalOut;

    assign opcode = bus.instruction[INSTR_WIDTH-1 -: 6];
    assign memOk  = (HAS_MEM_WAIT != 0) ? bus.mem_ready : 1'b1;

    if (INSTR_WIDTH > 6) begin : gLowBits
        logic unusedLowBits;
        assign unusedLowBits = ^bus.instruction[INSTR_WIDTH-7:0];
    end

    always_comb begin
        dispatchState = FETCH;
        decodeIllegal = 1'b0;
        case (opcode)
            OP_RTYPE:                 dispatchState = R_EXEC;
            OP_LW, OP_SW:             dispatchState = MEM_ADDR;
            OP_ADDI, OP_ANDI, OP_ORI: dispatchState = I_EXEC;
            OP_BEQ, OP_BNE:           dispatchState = BRANCH;
            OP_J:                     dispatchState = JUMP;
            OP_JAL: begin
                if (ENABLE_JAL != 0) dispatchState = JUMP;
                else                 decodeIllegal = 1'b1;
            end
            default:                  decodeIllegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            currentState <= FETCH;
            iOpSel       <= ALU_ADD;
            isBne        <= 1'b0;
            isJal        <= 1'b0;
        end else begin
            currentState <= nextState;
            // Instruction class is captured once so later states stay Moore.
            if (currentState == DECODE) begin
                iOpSel <= iOpFor(opcode);
                isBne  <= (opcode == OP_BNE);
                isJal  <= (opcode == OP_JAL);
            end
        end
    end

    mc_ctrl_outputs uOutputs (
        .state  (currentState),
        .iOpSel (iOpSel),
        .isBne  (isBne),
        .isJal  (isJal),
        .ctrl   (baseCtrl)
    );

    always_comb begin
        nextState  = FETCH;
        ctrlOut    = baseCtrl;
        illegalOut = 1'b0;
        case (currentState)
            FETCH:    nextState = memOk ? DECODE : FETCH;
            DECODE:   nextState = dispatchState;
            MEM_ADDR: nextState = (opcode == OP_SW) ? MEM_WR : MEM_RD;
            MEM_RD:   nextState = memOk ? MEM_WB : MEM_RD;
            MEM_WR:   nextState = memOk ? FETCH : MEM_WR;
            R_EXEC:   nextState = R_WB;
            I_EXEC:   nextState = I_WB;
            default:  nextState = FETCH;
        endcase
        // IR and PC load only on the cycle the fetch completes.
        if (currentState == FETCH && !memOk) begin
            ctrlOut.irWrite = 1'b0;
            ctrlOut.pcWrite = 1'b0;
        end
        // The illegal flag is the one output tied to the (stable) IR in DECODE.
        if (currentState == DECODE) illegalOut = decodeIllegal;
        // The state register clears asynchronously, but FETCH's own outputs are
        // non-zero, so the word is blanked while reset is held.
        if (reset) begin
            ctrlOut    = '0;
            illegalOut = 1'b0;
        end
    end

    assign bus.pc_write         = ctrlOut.pcWrite;
    assign bus.pc_write_cond    = ctrlOut.pcWriteCond;
    assign bus.pc_write_cond_ne = ctrlOut.pcWriteCondNe;
    assign bus.iord             = ctrlOut.iord;
    assign bus.mem_read         = ctrlOut.memRead;
    assign bus.mem_write        = ctrlOut.memWrite;
    assign bus.ir_write         = ctrlOut.irWrite;
    assign bus.reg_dst          = ctrlOut.regDst;
    assign bus.mem_to_reg       = ctrlOut.memToReg;
    assign bus.alu_src_a        = ctrlOut.aluSrcA;
    assign bus.alu_src_b        = ctrlOut.aluSrcB;
    assign bus.alu_op           = ALUOP_WIDTH'(ctrlOut.aluOp);
    assign bus.pc_source        = ctrlOut.pcSource;
    assign bus.reg_write        = ctrlOut.regWrite;
    assign bus.illegal_op       = illegalOut;
    assign bus.state            = currentState;
endmodule
